// File: rtl/pair_distance_pkg.sv
// Shared types for the squared-distance pipeline: pair metadata and retained top-K entries.
package pair_distance_pkg;
  localparam int INDEX_BIT_WIDTH = 32;
  localparam int COORD_BIT_WIDTH = 12;

  // Sum of two squared coordinate deltas plus headroom for a third axis of carry.
  function automatic int distance_sq_width(input int coord_w);
    return 2 * coord_w + 2;
  endfunction

  localparam int DISTANCE_SQ_BIT_WIDTH = distance_sq_width(COORD_BIT_WIDTH);

  typedef logic [DISTANCE_SQ_BIT_WIDTH-1:0] distance_sq_t;

  typedef struct packed {
    logic [INDEX_BIT_WIDTH-1:0] u;
    logic [INDEX_BIT_WIDTH-1:0] v;
  } pair_metadata_t;

  typedef struct packed {
    distance_sq_t   distance_sq;
    pair_metadata_t metadata;
  } topk_entry_t;
endpackage

// File: rtl/pair_distance_topk_if.sv
// Batch-in / sorted-drain-out bundle between the distance stage, top-K block and union stage.
interface pair_distance_topk_if #(
  parameter int BATCH_SIZE = 16
);
  import pair_distance_pkg::*;

  logic                              in_valid;
  logic                              in_ready;
  distance_sq_t   [BATCH_SIZE-1:0]   in_distances_sq;
  pair_metadata_t [BATCH_SIZE-1:0]   in_metadata;
  logic                              flush;
  logic                              out_valid;
  logic                              out_ready;
  distance_sq_t                      out_distance_sq;
  pair_metadata_t                    out_metadata;
  logic                              out_last;

  modport slave (
    input  in_valid, in_distances_sq, in_metadata, flush, out_ready,
    output in_ready, out_valid, out_distance_sq, out_metadata, out_last
  );

  modport master (
    output in_valid, in_distances_sq, in_metadata, flush, out_ready,
    input  in_ready, out_valid, out_distance_sq, out_metadata, out_last
  );
endinterface

// File: rtl/sorted_topk_array.sv
// K-entry ascending register file; one insert per cycle at the stable (after-ties) position.
module sorted_topk_array
  import pair_distance_pkg::*;
#(
  parameter int K = 1000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              ins_valid,
  input  topk_entry_t                       ins_entry,
  input  logic [((K > 1) ? $clog2(K) : 1)-1:0] rd_idx,
  output topk_entry_t                       rd_entry,
  output logic [$clog2(K+1)-1:0]            fill,
  output distance_sq_t                      tail_distance_sq
);
  localparam int FW = $clog2(K + 1);
  localparam logic [FW-1:0] K_FILL = FW'(K);

  topk_entry_t entries [K];
  topk_entry_t shifted [K];
  logic [K-1:0] le;

  // le is a prefix of ones over the valid region, so each slot only looks at itself and its neighbour.
  for (genvar i = 0; i < K; i++) begin : g_slot
    localparam logic [FW-1:0] IDX = FW'(i);
    assign le[i] = (IDX < fill) && (entries[i].distance_sq <= ins_entry.distance_sq);
    if (i == 0) begin : g_head
      assign shifted[i] = le[i] ? entries[i] : ins_entry;
    end else begin : g_body
      assign shifted[i] = le[i] ? entries[i] : (le[i-1] ? ins_entry : entries[i-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (ins_valid)
      for (int i = 0; i < K; i++) entries[i] <= shifted[i];
  end

  always_ff @(posedge clk) begin
    if (rst || clear)                      fill <= '0;
    else if (ins_valid && fill != K_FILL)  fill <= fill + FW'(1);
  end

  assign rd_entry         = entries[rd_idx];
  assign tail_distance_sq = entries[K-1].distance_sq;
endmodule

// File: rtl/pair_distance_topk.sv
// Serialises distance batches into a sorted top-K array and drains it in ascending order on flush.
module pair_distance_topk
  import pair_distance_pkg::*;
#(
  parameter int BATCH_SIZE = 16,
  parameter int K          = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  pair_distance_topk_if.slave     bus,
  output logic                    done,
  output logic [$clog2(K+1)-1:0]  fill
);
  localparam int FW = $clog2(K + 1);
  localparam int RW = (K > 1) ? $clog2(K) : 1;
  localparam int LW = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(BATCH_SIZE - 1);
  localparam logic [FW-1:0] K_FILL    = FW'(K);

  typedef enum logic [1:0] {ACCEPT, SCAN, DRAIN} state_t;

  state_t                          state;
  logic [LW-1:0]                   lane;
  logic [RW-1:0]                   rd;
  logic                            flush_pending;
  distance_sq_t   [BATCH_SIZE-1:0] batch_d;
  pair_metadata_t [BATCH_SIZE-1:0] batch_m;
  topk_entry_t                     lane_entry;
  topk_entry_t                     rd_entry;
  distance_sq_t                    tail_d;
  logic                            ins_valid;
  logic                            drain_fire;
  logic                            at_last;
  logic                            drain_end;

  assign bus.in_ready = !rst && (state == ACCEPT) && !flush_pending;

  assign lane_entry = '{distance_sq: batch_d[lane], metadata: batch_m[lane]};
  // v <= u marks a padded lane; a full array only takes strictly smaller distances.
  assign ins_valid  = (state == SCAN) && (lane_entry.metadata.v > lane_entry.metadata.u) &&
                      ((fill != K_FILL) || (lane_entry.distance_sq < tail_d));

  assign at_last    = (FW'(rd) == fill - FW'(1));
  assign drain_fire = (state == DRAIN) && bus.out_valid && bus.out_ready;
  assign drain_end  = drain_fire && at_last;

  assign bus.out_last        = bus.out_valid && at_last;
  assign bus.out_distance_sq = rd_entry.distance_sq;
  assign bus.out_metadata    = rd_entry.metadata;

  sorted_topk_array #(.K(K)) u_array (
    .clk              (clk),
    .rst              (rst),
    .clear            (drain_end),
    .ins_valid        (ins_valid),
    .ins_entry        (lane_entry),
    .rd_idx           (rd),
    .rd_entry         (rd_entry),
    .fill             (fill),
    .tail_distance_sq (tail_d)
  );

  always_ff @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) begin
      batch_d <= bus.in_distances_sq;
      batch_m <= bus.in_metadata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACCEPT;
      lane          <= '0;
      rd            <= '0;
      flush_pending <= 1'b0;
      bus.out_valid <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ACCEPT: begin
          if (bus.in_valid && bus.in_ready) begin
            lane          <= '0;
            flush_pending <= bus.flush;
            state         <= SCAN;
          end else if (bus.flush && bus.in_ready) begin
            if (fill != '0) begin
              state         <= DRAIN;
              rd            <= '0;
              bus.out_valid <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        SCAN: begin
          lane <= lane + LW'(1);
          if (lane == LAST_LANE) begin
            lane <= '0;
            // The final lane's insert lands this edge, so count it when deciding drain vs. empty.
            if (!flush_pending) begin
              state <= ACCEPT;
            end else if (fill != '0 || ins_valid) begin
              state         <= DRAIN;
              rd            <= '0;
              bus.out_valid <= 1'b1;
            end else begin
              state         <= ACCEPT;
              flush_pending <= 1'b0;
              done          <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_end) begin
            state         <= ACCEPT;
            rd            <= '0;
            flush_pending <= 1'b0;
            bus.out_valid <= 1'b0;
            done          <= 1'b1;
          end else if (drain_fire) begin
            rd <= rd + RW'(1);
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end
endmodule

// File: tb/tb_pair_distance_topk.sv
// Bench for pair_distance_topk with K=4, BATCH_SIZE=4: table vectors, corner sequences, random vs queue model.
module tb_pair_distance_topk;
  import pair_distance_pkg::*;

  localparam int B  = 4;
  localparam int KK = 4;
  localparam int DW = DISTANCE_SQ_BIT_WIDTH;
  localparam int MX = -1;

  typedef distance_sq_t   [B-1:0] dist4_t;
  typedef pair_metadata_t [B-1:0] meta4_t;
  typedef logic [B-1:0][31:0]     idx4_t;
  typedef struct {
    dist4_t d;
    meta4_t m;
    int     mode;
    int     n;
    dist4_t ed;
    idx4_t  ev;
    int     stall;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done;
  logic [$clog2(KK+1)-1:0] fill;
  int tests  = 0;
  int errors = 0;
  topk_entry_t model[$];
  topk_entry_t exp_q[$];
  rec_t recs[7];

  pair_distance_topk_if #(.BATCH_SIZE(B)) bus();

  pair_distance_topk #(.BATCH_SIZE(B), .K(KK)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .done (done),
    .fill (fill)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  function automatic dist4_t mkd(input int a0, input int a1, input int a2, input int a3);
    dist4_t r;
    r[0] = DW'(a0); r[1] = DW'(a1); r[2] = DW'(a2); r[3] = DW'(a3);
    return r;
  endfunction

  function automatic idx4_t mkv(input int v0, input int v1, input int v2, input int v3);
    idx4_t r;
    r[0] = 32'(v0); r[1] = 32'(v1); r[2] = 32'(v2); r[3] = 32'(v3);
    return r;
  endfunction

  function automatic meta4_t mkm(input int v0, input int v1, input int v2, input int v3, input int u23);
    meta4_t r;
    idx4_t  v = mkv(v0, v1, v2, v3);
    for (int i = 0; i < B; i++) begin
      r[i].u = (i >= 2) ? 32'(u23) : 32'd0;
      r[i].v = v[i];
    end
    return r;
  endfunction

  // Keep the K smallest pairs, ties in arrival order, padded lanes ignored.
  function automatic void model_insert(input topk_entry_t e);
    int p = 0;
    if (e.metadata.v <= e.metadata.u) return;
    if (model.size() >= KK && e.distance_sq >= model[KK-1].distance_sq) return;
    foreach (model[i]) if (model[i].distance_sq <= e.distance_sq) p++;
    model.insert(p, e);
    if (model.size() > KK) void'(model.pop_back());
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    tests++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 100) begin tick(); n++; end
    if (!bus.in_ready) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic apply_rst();
    rst = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    end
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("post_rst_fill", 64'(fill), 64'd0);
    chk("post_rst_done", 64'(done), 64'd0);
    model.delete();
  endtask

  task automatic send_batch(input dist4_t d, input meta4_t m, input logic fl, input logic hold);
    topk_entry_t e;
    wait_ready();
    bus.in_valid        = 1'b1;
    bus.in_distances_sq = d;
    bus.in_metadata     = m;
    bus.flush           = fl;
    tick();
    bus.flush = 1'b0;
    if (hold) bus.in_distances_sq = '0;
    else      bus.in_valid = 1'b0;
    for (int i = 0; i < B; i++) begin
      e.distance_sq = d[i];
      e.metadata    = m[i];
      model_insert(e);
    end
    for (int c = 0; c < B; c++) begin
      chk("scan_busy", 64'(bus.in_ready), 64'd0);
      tick();
    end
    if (!fl) begin
      chk("scan_done_ready", 64'(bus.in_ready), 64'd1);
      chk("scan_fill", 64'(fill), 64'(model.size()));
    end
  endtask

  task automatic send_flush();
    wait_ready();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic drain(input int stall);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("drain_valid", 64'(bus.out_valid), 64'd1);
      chk("drain_d", 64'(bus.out_distance_sq), 64'(exp_q[i].distance_sq));
      chk("drain_uv", 64'(bus.out_metadata), 64'(exp_q[i].metadata));
      chk("drain_last", 64'(bus.out_last), 64'(i == exp_q.size() - 1));
      if (i == stall) begin
        repeat (3) begin
          tick();
          chk("stall_valid", 64'(bus.out_valid), 64'd1);
          chk("stall_d", 64'(bus.out_distance_sq), 64'(exp_q[i].distance_sq));
          chk("stall_uv", 64'(bus.out_metadata), 64'(exp_q[i].metadata));
        end
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    chk("done_pulse", 64'(done), 64'd1);
    chk("idle_valid", 64'(bus.out_valid), 64'd0);
    chk("fill_clear", 64'(fill), 64'd0);
    tick();
    chk("done_once", 64'(done), 64'd0);
    chk("idle_ready", 64'(bus.in_ready), 64'd1);
    model.delete();
  endtask

  initial begin
    topk_entry_t e;
    dist4_t      rd_d;
    meta4_t      rd_m;
    int          mode;
    int          stall;

    bus.in_valid        = 1'b0;
    bus.flush           = 1'b0;
    bus.out_ready       = 1'b0;
    bus.in_distances_sq = '0;
    bus.in_metadata     = '0;

    recs[0] = '{d: mkd(9, 1, 4, 16),  m: mkm(1, 2, 3, 4, 0), mode: 1, n: 4,
                ed: mkd(1, 4, 9, 16), ev: mkv(2, 3, 1, 4), stall: -1};
    recs[1] = '{d: mkd(9, 1, 4, 16),  m: mkm(1, 2, 3, 4, 0), mode: 0, n: 0,
                ed: mkd(0, 0, 0, 0),  ev: mkv(0, 0, 0, 0), stall: -1};
    recs[2] = '{d: mkd(2, 20, 3, 0),  m: mkm(5, 6, 7, 8, 0), mode: 1, n: 4,
                ed: mkd(0, 1, 2, 3),  ev: mkv(8, 2, 5, 7), stall: 1};
    recs[3] = '{d: mkd(5, 5, 7, 7),   m: mkm(1, 2, 2, 0, 2), mode: 2, n: 2,
                ed: mkd(5, 5, 0, 0),  ev: mkv(1, 2, 0, 0), stall: -1};
    recs[4] = '{d: mkd(5, 5, 5, 5),   m: mkm(1, 2, 3, 4, 0), mode: 0, n: 0,
                ed: mkd(0, 0, 0, 0),  ev: mkv(0, 0, 0, 0), stall: -1};
    recs[5] = '{d: mkd(5, 6, MX, 5),  m: mkm(5, 6, 7, 8, 0), mode: 1, n: 4,
                ed: mkd(5, 5, 5, 5),  ev: mkv(1, 2, 3, 4), stall: 2};
    recs[6] = '{d: mkd(MX, 0, MX, 7), m: mkm(1, 2, 3, 4, 0), mode: 1, n: 4,
                ed: mkd(0, 7, MX, MX), ev: mkv(2, 4, 1, 3), stall: -1};

    apply_rst();

    // Empty flush: done pulse with no drain entries.
    send_flush();
    exp_q.delete();
    drain(-1);

    for (int r = 0; r < 7; r++) begin
      send_batch(recs[r].d, recs[r].m, recs[r].mode == 2, 1'b0);
      if (recs[r].mode == 1) send_flush();
      if (recs[r].mode != 0) begin
        exp_q.delete();
        for (int i = 0; i < recs[r].n; i++) begin
          e.distance_sq = recs[r].ed[i];
          e.metadata.u  = 32'd0;
          e.metadata.v  = recs[r].ev[i];
          exp_q.push_back(e);
        end
        drain(recs[r].stall);
      end
    end

    // in_valid held through SCAN and into DRAIN with zero-distance data: nothing extra may enter.
    send_batch(mkd(6, 3, 8, 1), mkm(1, 2, 3, 4, 0), 1'b1, 1'b1);
    repeat (2) begin
      chk("hold_fill", 64'(fill), 64'(model.size()));
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("hold_drain_valid", 64'(bus.out_valid), 64'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    exp_q = model;
    drain(0);

    // Reset during SCAN lane 2 with a full array.
    send_batch(recs[1].d, recs[1].m, 1'b0, 1'b0);
    wait_ready();
    bus.in_valid        = 1'b1;
    bus.in_distances_sq = mkd(1, 2, 3, 4);
    bus.in_metadata     = mkm(1, 2, 3, 4, 0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    apply_rst();

    // Reset after two drained entries.
    send_batch(recs[0].d, recs[0].m, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    apply_rst();

    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < B; i++) begin
        rd_d[i]   = ($urandom_range(0, 4) == 0) ? DW'(MX) : DW'($urandom_range(0, 12));
        rd_m[i].u = ($urandom_range(0, 3) == 0) ? 32'd7 : 32'd0;
        rd_m[i].v = 32'($urandom_range(0, 12));
      end
      mode  = int'($urandom_range(0, 2));
      stall = int'($urandom_range(0, 5)) - 1;
      send_batch(rd_d, rd_m, mode == 2, 1'b0);
      if (mode == 1) send_flush();
      if (mode != 0) begin
        exp_q = model;
        drain(stall);
      end
    end
    send_flush();
    exp_q = model;
    drain(-1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
